// File: rtl/dcache_pkg.sv
// Shared definitions for the data-cache controller: FSM states and
// address-field helpers. Build option: DCACHE_STATS_EN adds hit/miss counters.
package dcache_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Byte offset inside a 32-bit word.
  localparam int OFFSET_W = 2;

  // Tag width left over once the index and word offset are removed.
  function automatic int tag_w(input int idx_w);
    return 32 - idx_w - OFFSET_W;
  endfunction

endpackage

// File: rtl/dcache_array.sv
// Tag/data storage for the direct-mapped data cache: one synchronous write
// port, one asynchronous read port, no reset (valid bits live in the controller).
module dcache_array
  import dcache_pkg::*;
#(
  parameter int LINES = 64,
  parameter int IDX_W = $clog2(LINES),
  parameter int TAG_W = tag_w(IDX_W)
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [IDX_W-1:0] i_widx,
  input  logic [TAG_W-1:0] i_wtag,
  input  logic [31:0]      i_wdata,
  input  logic [IDX_W-1:0] i_ridx,
  output logic [TAG_W-1:0] o_rtag,
  output logic [31:0]      o_rdata
);

  logic [TAG_W-1:0] r_tag  [LINES];
  logic [31:0]      r_data [LINES];

  // Line update on fill or store hit.
  // NOTE: storage arrays are deliberately not reset; the controller's valid
  // bits decide whether a line's contents mean anything.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_tag[i_widx]  <= i_wtag;
      r_data[i_widx] <= i_wdata;
    end
  end

  assign o_rtag  = r_tag[i_ridx];
  assign o_rdata = r_data[i_ridx];

endmodule

// File: rtl/dcache_ctrl.sv
// Memory-stage data-cache controller: direct-mapped, one word per line,
// write-through, no-write-allocate, valid/ready handshake to main memory.
// Build option: define DCACHE_STATS_EN to add saturating hit_count/miss_count.
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int LINES = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] ReadDataM,
  output logic        Mem_Stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);

  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = tag_w(IDX_W);

  state_e           r_state;
  state_e           w_next;
  logic [LINES-1:0] r_valid;
  logic [29:0]      r_mem_word;
  logic             r_mem_we;
  logic [31:0]      r_mem_wdata;
  logic [31:0]      r_rdata;
  logic             r_store_hit;

  logic [IDX_W-1:0] w_idx;
  logic [TAG_W-1:0] w_tag;
  logic [IDX_W-1:0] w_req_idx;
  logic [TAG_W-1:0] w_req_tag;
  logic [TAG_W-1:0] w_line_tag;
  logic [31:0]      w_line_data;
  logic             w_hit;
  logic             w_idle;
  logic             w_arr_we;
  logic [31:0]      w_arr_wdata;
  logic             w_unused;

  // Lookup fields come from the live memory-stage address; fill/store fields
  // come from the address latched when the miss or store was accepted.
  assign w_idx     = ALUResultM[IDX_W+OFFSET_W-1:OFFSET_W];
  assign w_tag     = ALUResultM[31:IDX_W+OFFSET_W];
  assign w_req_idx = r_mem_word[IDX_W-1:0];
  assign w_req_tag = r_mem_word[29:IDX_W];
  assign w_hit     = r_valid[w_idx] && (w_line_tag == w_tag);
  assign w_idle    = (r_state == IDLE);
  assign w_unused  = &{1'b0, ALUResultM[OFFSET_W-1:0]};

  // Fills always write the line; a store only refreshes a line it hits.
  assign w_arr_we    = mem_ready && ((r_state == FILL) || ((r_state == WRITE) && r_store_hit));
  assign w_arr_wdata = (r_state == FILL) ? mem_rdata : r_mem_wdata;

  dcache_array #(
    .LINES (LINES),
    .IDX_W (IDX_W),
    .TAG_W (TAG_W)
  ) u_array (
    .clk     (clk),
    .i_we    (w_arr_we),
    .i_widx  (w_req_idx),
    .i_wtag  (w_req_tag),
    .i_wdata (w_arr_wdata),
    .i_ridx  (w_idx),
    .o_rtag  (w_line_tag),
    .o_rdata (w_line_data)
  );

  // State register; reset aborts any in-flight memory transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Next-state, stall and request decode.
  // NOTE: every output of this block gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    w_next    = r_state;
    Mem_Stall = 1'b0;
    mem_req   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (MemWriteM) begin
          Mem_Stall = 1'b1;
          w_next    = WRITE;
        end else if (MemReadM && !w_hit) begin
          Mem_Stall = 1'b1;
          w_next    = FILL;
        end
      end
      FILL, WRITE: begin
        mem_req   = 1'b1;
        Mem_Stall = 1'b1;
        if (mem_ready) w_next = DONE;
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Request latching, valid bits and captured load data.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid     <= '0;
      r_mem_word  <= '0;
      r_mem_we    <= 1'b0;
      r_mem_wdata <= '0;
      r_rdata     <= '0;
      r_store_hit <= 1'b0;
    end else begin
      if (w_idle && MemWriteM) begin
        r_mem_word  <= ALUResultM[31:OFFSET_W];
        r_mem_we    <= 1'b1;
        r_mem_wdata <= WriteDataM;
        r_store_hit <= w_hit;
      end else if (w_idle && MemReadM && !w_hit) begin
        r_mem_word <= ALUResultM[31:OFFSET_W];
        r_mem_we   <= 1'b0;
      end
      if ((r_state == FILL) && mem_ready) begin
        r_valid[w_req_idx] <= 1'b1;
        r_rdata            <= mem_rdata;
      end
    end
  end

  assign mem_addr  = {r_mem_word, 2'b00};
  assign mem_we    = r_mem_we;
  assign mem_wdata = r_mem_wdata;

  // DONE returns the captured fill data; otherwise an empty line reads as zero.
  assign ReadDataM = (r_state == DONE) ? r_rdata :
                     (r_valid[w_idx] ? w_line_data : 32'h0);

`ifdef DCACHE_STATS_EN
  // Saturating load hit/miss counters, sampled on the IDLE lookup only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (w_idle && MemReadM && !MemWriteM) begin
      if (w_hit) begin
        if (hit_count != 32'hFFFF_FFFF) hit_count <= hit_count + 32'd1;
      end else begin
        if (miss_count != 32'hFFFF_FFFF) miss_count <= miss_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl: directed scenarios followed by random
// loads/stores compared against a line-level cache and memory model.
module tb_dcache_ctrl;

  localparam int LINES = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        MemReadM = 1'b0;
  logic        MemWriteM = 1'b0;
  logic [31:0] ALUResultM = '0;
  logic [31:0] WriteDataM = '0;
  logic [31:0] ReadDataM;
  logic        Mem_Stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ready = 1'b0;
`ifdef DCACHE_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  dcache_ctrl #(.LINES(LINES)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .MemReadM   (MemReadM),
    .MemWriteM  (MemWriteM),
    .ALUResultM (ALUResultM),
    .WriteDataM (WriteDataM),
    .ReadDataM  (ReadDataM),
    .Mem_Stall  (Mem_Stall),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready)
`ifdef DCACHE_STATS_EN
    ,
    .hit_count  (hit_count),
    .miss_count (miss_count)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: per-line cached word address and data, plus main memory.
  bit          m_valid [LINES];
  bit   [29:0] m_wa    [LINES];
  logic [31:0] m_data  [LINES];
  logic [31:0] mem_model [bit [29:0]];
  int          m_hits = 0;
  int          m_misses = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_read(input bit [29:0] wa);
    if (mem_model.exists(wa)) return mem_model[wa];
    return {2'b00, wa} ^ 32'hC0DE_0000;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
    m_hits   = 0;
    m_misses = 0;
  endtask

  // One memory-stage access starting at a negedge; memory answers after lat
  // cycles of mem_req. Returns at the negedge where the next access may start.
  task automatic access(input bit wr, input bit rd, input logic [31:0] addr,
                        input logic [31:0] wd, input int lat);
    bit [29:0]   wa;
    int          idx;
    bit          hit;
    int          stall;
    logic [31:0] exp_rd;
    wa  = addr[31:2];
    idx = int'(wa % LINES);
    hit = m_valid[idx] && (m_wa[idx] == wa);
    MemWriteM  = wr;
    MemReadM   = rd;
    ALUResultM = {addr[31:2], 2'(($urandom_range(0, 3)))};
    WriteDataM = wd;
    mem_ready  = 1'($urandom_range(0, 1));
    mem_rdata  = $urandom;
    #1;
    if (!wr && !rd) begin
      check("idle_stall", {31'b0, Mem_Stall}, 32'd0);
      @(negedge clk);
      return;
    end
    if (!wr && hit) begin
      check("hit_stall", {31'b0, Mem_Stall}, 32'd0);
      check("hit_data", ReadDataM, m_data[idx]);
      m_hits++;
      @(negedge clk);
      return;
    end
    if (!wr) m_misses++;
    exp_rd = mem_read(wa);
    stall  = Mem_Stall ? 1 : 0;
    check("detect_req", {31'b0, mem_req}, 32'd0);
    for (int c = 1; c <= lat; c++) begin
      @(negedge clk);
      mem_ready = (c == lat);
      mem_rdata = (c == lat && !wr) ? exp_rd : $urandom;
      #1;
      if (Mem_Stall) stall++;
      check("xfer_req", {31'b0, mem_req}, 32'd1);
      check("xfer_we", {31'b0, mem_we}, {31'b0, wr});
      check("xfer_addr", mem_addr, {wa, 2'b00});
      if (wr) check("xfer_wdata", mem_wdata, wd);
    end
    @(negedge clk);
    mem_ready = 1'b0;
    mem_rdata = $urandom;
    #1;
    check("stall_cycles", stall, lat + 1);
    check("done_stall", {31'b0, Mem_Stall}, 32'd0);
    check("done_req", {31'b0, mem_req}, 32'd0);
    if (!wr) check("done_data", ReadDataM, exp_rd);
    if (wr) begin
      mem_model[wa] = wd;
      if (hit) m_data[idx] = wd;
    end else begin
      m_valid[idx] = 1'b1;
      m_wa[idx]    = wa;
      m_data[idx]  = exp_rd;
    end
    @(negedge clk);
  endtask

  initial begin
    model_reset();
    mem_model[30'h40] = 32'hDEAD_BEEF;   // word at byte address 0x100

    #3;
    check("rst_stall", {31'b0, Mem_Stall}, 32'd0);
    check("rst_req", {31'b0, mem_req}, 32'd0);
    check("rst_we", {31'b0, mem_we}, 32'd0);
    check("rst_addr", mem_addr, 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    check("rst_rdata", ReadDataM, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Fill, hit, store hit, read back.
    access(1'b0, 1'b1, 32'h0000_0100, 32'h0, 3);
    access(1'b0, 1'b1, 32'h0000_0100, 32'h0, 1);
    access(1'b1, 1'b0, 32'h0000_0100, 32'h1234_5678, 2);
    access(1'b0, 1'b1, 32'h0000_0100, 32'h0, 1);
    // Store miss does not allocate.
    access(1'b1, 1'b0, 32'h0000_0200, 32'hCAFE_F00D, 1);
    access(1'b0, 1'b1, 32'h0000_0200, 32'h0, 2);
    // Same-index conflict evictions.
    access(1'b0, 1'b1, 32'h0000_0100, 32'h0, 1);
    access(1'b0, 1'b1, 32'h0000_0200, 32'h0, 4);
    access(1'b0, 1'b1, 32'h0000_0100, 32'h0, 1);
    // Both controls high: the store wins.
    access(1'b1, 1'b1, 32'h0000_0100, 32'hA5A5_5A5A, 2);
    access(1'b0, 1'b1, 32'h0000_0100, 32'h0, 1);

    // Reset pulse in the middle of a fill.
    MemReadM   = 1'b1;
    MemWriteM  = 1'b0;
    ALUResultM = 32'h0000_0300;
    #1;
    check("mid_detect", {31'b0, Mem_Stall}, 32'd1);
    @(negedge clk);
    #1;
    check("mid_fill_req", {31'b0, mem_req}, 32'd1);
    #1;
    rst_n    = 1'b0;
    MemReadM = 1'b0;
    #1;
    check("mid_rst_req", {31'b0, mem_req}, 32'd0);
    check("mid_rst_stall", {31'b0, Mem_Stall}, 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    access(1'b0, 1'b1, 32'h0000_0100, 32'h0, 2);

    // Random traffic over a small address pool to force hits and conflicts.
    for (int n = 0; n < 300; n++) begin
      bit [29:0] wa;
      int        op;
      wa = 30'(($urandom_range(0, 3) << 6) | $urandom_range(0, 7));
      op = $urandom_range(0, 99);
      if (op < 45)      access(1'b0, 1'b1, {wa, 2'b00}, 32'h0, $urandom_range(1, 4));
      else if (op < 80) access(1'b1, 1'b0, {wa, 2'b00}, $urandom, $urandom_range(1, 4));
      else if (op < 92) access(1'b0, 1'b0, {wa, 2'b00}, 32'h0, 1);
      else              access(1'b1, 1'b1, {wa, 2'b00}, $urandom, $urandom_range(1, 4));
    end

`ifdef DCACHE_STATS_EN
    check("hit_count", hit_count, 32'(m_hits));
    check("miss_count", miss_count, 32'(m_misses));
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
